// File: rtl/bar_frame_writer.sv
// Bar-chart renderer: draws a 96x64 RGB565 frame into the back bank
// of a dual-bank frame buffer, then swaps banks on the next frame_begin.
module bar_frame_writer #(
  parameter int          NUM_BARS   = 5,
  parameter int          BAR_WIDTH  = 8,
  parameter int          BAR_PITCH  = 20,
  parameter logic [15:0] BAR_COLOR  = 16'h07E0,
  parameter logic [15:0] CMP_COLOR  = 16'hFFE0,
  parameter logic [15:0] DONE_COLOR = 16'hF800,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7*NUM_BARS-1:0]   heights_flat,
  input  logic [2:0]              cmp_idx,
  input  logic [2:0]              done_from,
  input  logic                    highlight_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    frame_begin,
  output logic                    fb_we,
  output logic                    fb_wbank,
  output logic [12:0]             fb_addr,
  output logic [15:0]             fb_wdata,
  output logic                    fb_sel,
  output logic                    busy,
  output logic                    frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    WAIT_SWAP
  } state_t;

  state_t      state;
  logic [6:0]  h_q [NUM_BARS];
  logic [2:0]  cmp_q;
  logic [2:0]  done_q;
  logic        hl_q;
  logic [6:0]  x_q;
  logic [5:0]  y_q;
  logic [6:0]  k_q;
  logic [7:0]  off_q;
  logic [12:0] addr_q;

  logic [6:0]  cur_h;
  logic [3:0]  cmp_hi;
  logic        lit;
  logic        is_done;
  logic        is_cmp;
  logic [15:0] pix;
  logic        last;

  assign fb_wbank = ~fb_sel;

  // Colour of the pixel at the current (x, y) draw position
  always_comb begin
    cur_h = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      if (k_q == 7'(i)) cur_h = h_q[i];
    end
    lit = (k_q < 7'(NUM_BARS))
       && (off_q < 8'(BAR_WIDTH))
       && ({1'b0, 6'd63 - y_q} < cur_h);
    cmp_hi  = {1'b0, cmp_q} + 4'd1;
    is_done = hl_q && (k_q >= {4'b0, done_q});
    is_cmp  = hl_q && ((k_q == {4'b0, cmp_q})
                    || (k_q == {3'b0, cmp_hi}));
    if (!lit)         pix = BG_COLOR;
    else if (is_done) pix = DONE_COLOR;
    else if (is_cmp)  pix = CMP_COLOR;
    else              pix = BAR_COLOR;
    last = (addr_q == 13'd6143);
  end

  // Control FSM, raster counters and registered write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_sel     <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) h_q[i] <= '0;
      cmp_q      <= '0;
      done_q     <= '0;
      hl_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      k_q        <= '0;
      off_q      <= '0;
      addr_q     <= '0;
    end else begin
      frame_done <= 1'b0;
      fb_we      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            for (int i = 0; i < NUM_BARS; i++)
              h_q[i] <= heights_flat[7*i +: 7];
            cmp_q      <= cmp_idx;
            done_q     <= done_from;
            hl_q       <= highlight_en;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= DRAW;
          end
        end
        DRAW: begin
          fb_we    <= 1'b1;
          fb_addr  <= addr_q;
          fb_wdata <= pix;
          addr_q   <= addr_q + 13'd1;
          if (x_q == 7'd95) begin
            x_q   <= '0;
            k_q   <= '0;
            off_q <= '0;
            y_q   <= y_q + 6'd1;
          end else begin
            x_q <= x_q + 7'd1;
            if (off_q == 8'(BAR_PITCH - 1)) begin
              off_q <= '0;
              k_q   <= k_q + 7'd1;
            end else begin
              off_q <= off_q + 8'd1;
            end
          end
          if (last) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (frame_begin) begin
            fb_sel     <= ~fb_sel;
            frame_done <= 1'b1;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_frame_writer.sv
// Bench for bar_frame_writer: scoreboard of expected writes from a
// division-based pixel model, plus directed swap/reset checks.
module tb_bar_frame_writer;

  localparam int NB = 5;
  localparam int BW = 8;
  localparam int BP = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [34:0]   heights_flat = '0;
  logic [2:0]    cmp_idx = '0;
  logic [2:0]    done_from = '0;
  logic          highlight_en = 1'b0;
  logic          load_valid = 1'b0;
  logic          frame_begin = 1'b0;
  logic          load_ready;
  logic          fb_we;
  logic          fb_wbank;
  logic [12:0]   fb_addr;
  logic [15:0]   fb_wdata;
  logic          fb_sel;
  logic          busy;
  logic          frame_done;

  bar_frame_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .heights_flat (heights_flat),
    .cmp_idx      (cmp_idx),
    .done_from    (done_from),
    .highlight_en (highlight_en),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .frame_begin  (frame_begin),
    .fb_we        (fb_we),
    .fb_wbank     (fb_wbank),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .fb_sel       (fb_sel),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [15:0] data;
    logic        bank;
  } wr_t;

  wr_t         q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          nwrites = 0;
  int          ndone = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          exp_first = 0;
  logic        prev_we = 1'b0;
  logic [15:0] fbmem [6144];
  int          hts [NB];
  int          ci;
  int          df;
  bit          he;
  logic        exp_sel = 1'b0;
  int          base;
  int          d0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented write must match the next expected
  always @(negedge clk) begin
    if (frame_done) ndone++;
    if (reset_n && fb_we) begin
      if (!prev_we) first_cyc = cyc;
      last_cyc = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h", fb_addr, fb_wdata);
      end else begin
        mon_e = q.pop_front();
        if ({fb_addr, fb_wdata, fb_wbank} !==
            {mon_e.addr[12:0], mon_e.data, mon_e.bank}) begin
          errors++;
          $display("FAIL pixel_write: got addr %0d data %0h bank %0b expected addr %0d data %0h bank %0b",
                   fb_addr, fb_wdata, fb_wbank, mon_e.addr, mon_e.data, mon_e.bank);
        end
      end
      if (fb_addr < 13'd6144) fbmem[fb_addr] = fb_wdata;
      nwrites++;
    end
    prev_we = fb_we;
  end

  function automatic logic [15:0] model_pix(int x, int y);
    int k;
    int off;
    k = x / BP;
    off = x % BP;
    if (k >= NB || off >= BW) return 16'h0000;
    if ((63 - y) >= hts[k]) return 16'h0000;
    if (he && k >= df) return 16'hF800;
    if (he && (k == ci || k == ci + 1)) return 16'hFFE0;
    return 16'h07E0;
  endfunction

  task automatic push_frame(logic bank);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 96; x++)
        q.push_back('{y * 96 + x, model_pix(x, y), bank});
  endtask

  task automatic randomize_cfg();
    for (int k = 0; k < NB; k++) hts[k] = $urandom_range(0, 127);
    ci = $urandom_range(0, 7);
    df = $urandom_range(0, 7);
    he = 1'($urandom_range(0, 1));
  endtask

  task automatic start_draw(bit hold);
    @(negedge clk);
    for (int k = 0; k < NB; k++) heights_flat[7*k +: 7] = 7'(hts[k]);
    cmp_idx = 3'(ci);
    done_from = 3'(df);
    highlight_en = he;
    load_valid = 1'b1;
    chk("ready_before_load", {31'b0, load_ready}, 32'd1);
    push_frame(~exp_sel);
    exp_first = cyc + 2;
    base = nwrites;
    @(negedge clk);
    if (!hold) load_valid = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("ready_low_after_accept", {31'b0, load_ready}, 32'd0);
  endtask

  task automatic wait_writes(int target);
    for (int i = 0; i < 7000 && nwrites < target; i++) @(negedge clk);
    chk("reach_write_count", {31'b0, nwrites >= target}, 32'd1);
  endtask

  task automatic wait_draw();
    for (int i = 0; i < 7000; i++) begin
      if (nwrites >= base + 6144 && !fb_we) break;
      @(negedge clk);
    end
    chk("frame_write_count", 32'(nwrites), 32'(base + 6144));
    chk("first_write_latency", 32'(first_cyc), 32'(exp_first));
    chk("consecutive_writes", 32'(last_cyc - first_cyc), 32'd6143);
    chk("wait_swap_busy", {31'b0, busy}, 32'd1);
    chk("wait_swap_not_ready", {31'b0, load_ready}, 32'd0);
  endtask

  task automatic swap(int delay);
    repeat (delay) @(negedge clk);
    chk("no_swap_before_begin", {31'b0, fb_sel}, {31'b0, exp_sel});
    d0 = ndone;
    frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
    exp_sel = ~exp_sel;
    chk("swap_fb_sel", {31'b0, fb_sel}, {31'b0, exp_sel});
    chk("swap_frame_done", {31'b0, frame_done}, 32'd1);
    chk("swap_load_ready", {31'b0, load_ready}, 32'd1);
    chk("swap_busy_low", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("frame_done_one_cycle", {31'b0, frame_done}, 32'd0);
    chk("frame_done_count", 32'(ndone), 32'(d0 + 1));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fb_we", {31'b0, fb_we}, 32'd0);
    chk("rst_fb_addr", {19'b0, fb_addr}, 32'd0);
    chk("rst_fb_wdata", {16'b0, fb_wdata}, 32'd0);
    chk("rst_fb_sel", {31'b0, fb_sel}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    reset_n = 1'b1;

    // plain bars, first bank
    hts = '{10, 20, 30, 40, 50};
    he = 0; ci = 0; df = 7;
    start_draw(0);
    wait_draw();
    chk("px_5184", {16'b0, fbmem[5184]}, 32'h07E0);
    chk("px_5088", {16'b0, fbmem[5088]}, 32'h0000);
    chk("px_6056", {16'b0, fbmem[6056]}, 32'h0000);
    chk("px_6068", {16'b0, fbmem[6068]}, 32'h07E0);
    swap(10);

    // same draw goes to the other bank
    start_draw(0);
    wait_draw();
    swap(3);

    // highlight colouring on full columns
    hts = '{64, 64, 64, 64, 64};
    he = 1; ci = 1; df = 4;
    start_draw(0);
    wait_draw();
    chk("hl_x0", {16'b0, fbmem[0]}, 32'h07E0);
    chk("hl_x20", {16'b0, fbmem[20]}, 32'hFFE0);
    chk("hl_x40", {16'b0, fbmem[40]}, 32'hFFE0);
    chk("hl_x60", {16'b0, fbmem[60]}, 32'h07E0);
    chk("hl_x80", {16'b0, fbmem[80]}, 32'hF800);
    swap(1);

    // frame_begin mid-draw and load_valid held high
    randomize_cfg();
    start_draw(1);
    wait_writes(base + 3000);
    d0 = ndone;
    @(negedge clk);
    frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
    wait_draw();
    repeat (20) @(negedge clk);
    chk("no_second_accept", 32'(nwrites), 32'(base + 6144));
    chk("no_early_swap_sel", {31'b0, fb_sel}, {31'b0, exp_sel});
    chk("no_early_frame_done", 32'(ndone), 32'(d0));
    chk("still_busy", {31'b0, busy}, 32'd1);
    load_valid = 1'b0;
    swap(2);

    // height boundaries
    hts = '{0, 127, 64, 1, 63};
    he = 0; ci = 0; df = 7;
    start_draw(0);
    wait_draw();
    chk("h0_empty", {16'b0, fbmem[63*96+0]}, 32'h0000);
    chk("h127_top", {16'b0, fbmem[20]}, 32'h07E0);
    chk("h64_top", {16'b0, fbmem[40]}, 32'h07E0);
    chk("h1_bottom", {16'b0, fbmem[63*96+60]}, 32'h07E0);
    chk("h1_above", {16'b0, fbmem[62*96+60]}, 32'h0000);
    chk("h63_y1", {16'b0, fbmem[1*96+80]}, 32'h07E0);
    chk("h63_y0", {16'b0, fbmem[80]}, 32'h0000);
    swap(0);

    // reset in the middle of a draw
    randomize_cfg();
    start_draw(0);
    wait_writes(base + 2000);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_fb_we", {31'b0, fb_we}, 32'd0);
    chk("abort_fb_addr", {19'b0, fb_addr}, 32'd0);
    chk("abort_fb_sel", {31'b0, fb_sel}, 32'd0);
    chk("abort_load_ready", {31'b0, load_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    q.delete();
    exp_sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    randomize_cfg();
    start_draw(0);
    wait_draw();
    swap(1);

    // randomized frames
    for (int n = 0; n < 2; n++) begin
      randomize_cfg();
      start_draw(0);
      wait_draw();
      swap($urandom_range(0, 15));
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
